keypad_scanner: RTL and testbench

//  Matrix keypad scanner that sits directly after the pad I/O. It drives the

---
 rtl/keypad_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 33 +++
 rtl/keypad_scanner.sv | 196 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared definitions for the matrix keypad scanner:
//     kp_state_t      scanner FSM state encoding (SCAN / CONFIRM / HELD)
//     KP_* defaults   timing defaults for a 27 MHz system clock
//     key_w()         width of the coded key output for a ROWS x COLS matrix
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2
  } kp_state_t;

  localparam int KP_ROWS       = 4;
  localparam int KP_COLS       = 4;
  localparam int KP_SETTLE_CYC = 270;       // ~10 us column settle
  localparam int KP_DB_CYC     = 1048576;   // ~39 ms press/release qualification
  localparam int KP_REPEAT_CYC = 13500000;  // 0.5 s auto-repeat period

  // Width of key_code = row*COLS+col; never narrower than one bit.
  function automatic int key_w(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-stage synchronizer for asynchronous level inputs. Both stages reset
//   to all-ones so idle pulled-up lines read as "released" out of reset.
// Ports:
//   clk      in   1   system clock
//   n_reset  in   1   synchronous, active-low reset
//   d        in   W   asynchronous input
//   q        out  W   synchronized output (2-cycle latency)
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a ROWS x COLS matrix keypad by pulling one column low at a time and
//   sampling the (synchronized) row lines. A candidate key must stay stable
//   for DB_CYC cycles before it is accepted, and the held row must read open
//   for DB_CYC consecutive cycles before the release is accepted. Each accepted
//   press produces a one-cycle key_valid with key_code = row*COLS+col.
//   Optional auto-repeat: define KEYPAD_REPEAT_EN.
// Ports:
//   clk        in   1      system clock
//   n_reset    in   1      synchronous, active-low reset
//   row_n      in   ROWS   raw row lines, low = closed contact, asynchronous
//   col_n      out  COLS   column drive, exactly one bit low
//   key_code   out  KW     coded key, valid with key_valid, holds last value
//   key_valid  out  1      one-cycle pulse per accepted press / repeat
//   key_held   out  1      high from accept until release is qualified
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS       = KP_ROWS,
  parameter int COLS       = KP_COLS,
  parameter int SETTLE_CYC = KP_SETTLE_CYC,
  parameter int DB_CYC     = KP_DB_CYC,
  parameter int REPEAT_CYC = KP_REPEAT_CYC,
  localparam int KW        = key_w(ROWS, COLS)
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic [ROWS-1:0] row_n,
  output logic [COLS-1:0] col_n,
  output logic [KW-1:0]   key_code,
  output logic            key_valid,
  output logic            key_held
);

  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW      = (COLS > 1) ? $clog2(COLS) : 1;
  // One counter serves the settle window (SCAN) and both debounce windows.
  localparam int CNT_MAX = (SETTLE_CYC > DB_CYC - 1) ? SETTLE_CYC : DB_CYC - 1;
  localparam int CNTW    = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  logic [ROWS-1:0] rs;
  kp_state_t       state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [COLS-1:0] col_n_q, col_n_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [RW-1:0]   row_q, row_d, first_row;
  logic [ROWS-1:0] pat_q, pat_d;
  logic [KW-1:0]   key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_held_q, key_held_d;

`ifdef KEYPAD_REPEAT_EN
  // Counts HELD cycles with the key down. The first repeat fires when it
  // reaches DB_CYC+REPEAT_CYC-1; reloading DB_CYC makes later repeats land
  // every REPEAT_CYC cycles.
  localparam int RPT_TOP = DB_CYC + REPEAT_CYC - 1;
  localparam int RPTW    = $clog2(RPT_TOP + 1);
  logic [RPTW-1:0] rpt_q, rpt_d;
`endif

  sync_2ff #(.W(ROWS)) u_row_sync (
    .clk     (clk),
    .n_reset (n_reset),
    .d       (row_n),
    .q       (rs)
  );

  function automatic logic [CNTW-1:0] cnt_inc(input logic [CNTW-1:0] v);
    return (v == CNTW'(CNT_MAX)) ? v : v + CNTW'(1);
  endfunction

  // Lowest-index closed row wins on a multi-key press.
  always_comb begin
    first_row = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!rs[r]) first_row = RW'(r);
    end
  end

  // Column drive decoded from the next column index so col_n is a flop output.
  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    assign col_n_d[gi] = (col_d != CW'(gi));
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    pat_d       = pat_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
`ifdef KEYPAD_REPEAT_EN
    rpt_d       = '0;
`endif
    case (state_q)
      SCAN: begin
        if (cnt_q < CNTW'(SETTLE_CYC)) begin
          cnt_d = cnt_inc(cnt_q);
        end else if (&rs) begin
          col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
          cnt_d = '0;
        end else begin
          pat_d   = rs;
          row_d   = first_row;
          state_d = CONFIRM;
          cnt_d   = '0;
        end
      end
      CONFIRM: begin
        if (rs != pat_q) begin
          state_d = SCAN;
          cnt_d   = '0;
        end else if (cnt_q == CNTW'(DB_CYC - 1)) begin
          key_code_d  = KW'(int'(row_q) * COLS + int'(col_q));
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          state_d     = HELD;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_inc(cnt_q);
        end
      end
      HELD: begin
        // Only the accepted row matters; other keys are ignored.
        if (rs[row_q]) begin
`ifdef KEYPAD_REPEAT_EN
          rpt_d = rpt_q;  // contact open: freeze the repeat phase
`endif
          if (cnt_q == CNTW'(DB_CYC - 1)) begin
            key_held_d = 1'b0;
            state_d    = SCAN;
            col_d      = '0;
            cnt_d      = '0;
`ifdef KEYPAD_REPEAT_EN
            rpt_d      = '0;
`endif
          end else begin
            cnt_d = cnt_inc(cnt_q);
          end
        end else begin
          cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
          if (rpt_q == RPTW'(RPT_TOP)) begin
            key_valid_d = 1'b1;
            rpt_d       = RPTW'(DB_CYC);
          end else begin
            rpt_d = rpt_q + RPTW'(1);
          end
`endif
        end
      end
      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q     <= SCAN;
      col_q       <= '0;
      col_n_q     <= ~COLS'(1);
      cnt_q       <= '0;
      row_q       <= '0;
      pat_q       <= '1;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      col_n_q     <= col_n_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      pat_q       <= pat_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
`ifdef KEYPAD_REPEAT_EN
      rpt_q       <= rpt_d;
`endif
    end
  end

  assign col_n     = col_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Directed bench for keypad_scanner with short timing parameters. A keypad
//   matrix model closes row lines only while the matching column is driven.
//   Expected key codes are queued when a press is applied and checked by a
//   monitor whenever key_valid pulses.
module tb_keypad_scanner;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int SETTLE = 4;
  localparam int DB     = 16;
  localparam int REP    = 64;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] press_mask = '0;   // bit r*COLS+c = key (r,c) closed
  logic [3:0]  glitch = '0;       // forces a row low regardless of column

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pulse_cnt = 0;
  int exp_q[$];
  int pulse_t[$];

  keypad_scanner #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .SETTLE_CYC (SETTLE),
    .DB_CYC     (DB),
    .REPEAT_CYC (REP)
  ) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    row_n = ~glitch;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (press_mask[r*COLS+c] && !col_n[c]) row_n[r] = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Scoreboard: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (n_reset && key_valid) begin
      pulse_cnt++;
      pulse_t.push_back(cyc);
      chk("valid_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("key_code", key_code, exp_q.pop_front());
      chk("held_at_valid", key_held, 1);
    end
  end

  task automatic wait_pulses(input string tag, input int target, input int bound);
    int k = 0;
    while (pulse_cnt < target && k < bound) begin
      @(negedge clk);
      k++;
    end
    #1;
    chk(tag, pulse_cnt, target);
  endtask

  task automatic wait_held_low(input string tag, input int bound);
    int k = 0;
    while (key_held !== 1'b0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk(tag, key_held, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_col_n"}, col_n, 4'b1110);
    chk({tag, "_key_code"}, key_code, 0);
    chk({tag, "_key_valid"}, key_valid, 0);
    chk({tag, "_key_held"}, key_held, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int t0;
    int t_last;
    int k;
    logic [3:0] exp_coln;
    logic [3:0] col_snap;

    // ---- reset state ----
    n_reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    n_reset = 1'b1;

    // ---- 1: idle scan, each column held 5 cycles ----
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      exp_coln = ~(4'b0001 << ((i / 5) % 4));
      chk("scan_col", col_n, exp_coln);
    end
    chk("idle_no_valid", pulse_cnt, 0);

    // ---- 2: key row2/col1, exact release timing ----
    base = pulse_cnt;
    exp_q.push_back(9);
    press_mask[2*COLS+1] = 1'b1;
    wait_pulses("t2_pulse", base + 1, 150);
    repeat (20) @(negedge clk);
    chk("t2_held_while_down", key_held, 1);
    press_mask = '0;
    repeat (17) @(negedge clk);
    chk("t2_held_before_release", key_held, 1);
    @(negedge clk);
    chk("t2_released", key_held, 0);
    chk("t2_scan_restart_col0", col_n, 4'b1110);
    chk("t2_single_pulse", pulse_cnt, base + 1);

    // ---- 3: bouncy row1/col3 ----
    base = pulse_cnt;
    exp_q.push_back(7);
    for (int i = 0; i < 10; i++) begin
      press_mask[1*COLS+3] = ~press_mask[1*COLS+3];
      repeat (3) @(negedge clk);
    end
    chk("t3_no_pulse_in_bounce", pulse_cnt, base);
    press_mask[1*COLS+3] = 1'b1;
    t_last = cyc;
    wait_pulses("t3_pulse", base + 1, 150);
    if (pulse_cnt > base) chk("t3_gap_ge_db", (pulse_t[base] - t_last) >= DB, 1);
    press_mask = '0;
    wait_held_low("t3_release", 60);

    // ---- 4: short glitch on row0 ----
    base = pulse_cnt;
    glitch[0] = 1'b1;
    repeat (10) @(negedge clk);
    glitch = '0;
    repeat (40) @(negedge clk);
    chk("t4_no_pulse", pulse_cnt, base);
    col_snap = col_n;
    k = 0;
    while (col_n == col_snap && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("t4_scan_resumes", col_n != col_snap, 1);

    // ---- 5: rows 1 and 3 on col0, lowest row wins ----
    base = pulse_cnt;
    exp_q.push_back(4);
    press_mask[1*COLS+0] = 1'b1;
    press_mask[3*COLS+0] = 1'b1;
    wait_pulses("t5_pulse", base + 1, 150);
    press_mask[3*COLS+0] = 1'b0;
    repeat (30) @(negedge clk);
    chk("t5_held_after_row3_release", key_held, 1);
    chk("t5_no_extra_pulse", pulse_cnt, base + 1);
    press_mask = '0;
    wait_held_low("t5_release", 60);

    // ---- 6: key 9 held 200 cycles (auto-repeat if enabled) ----
    base = pulse_cnt;
`ifdef KEYPAD_REPEAT_EN
    repeat (3) exp_q.push_back(9);
`else
    exp_q.push_back(9);
`endif
    press_mask[2*COLS+1] = 1'b1;
    wait_pulses("t6_first_pulse", base + 1, 150);
    t0 = (pulse_cnt > base) ? pulse_t[base] : cyc;
    while (cyc < t0 + 200) @(negedge clk);
    press_mask = '0;
    wait_held_low("t6_release", 60);
`ifdef KEYPAD_REPEAT_EN
    chk("t6_pulse_count", pulse_cnt, base + 3);
    if (pulse_cnt >= base + 3) begin
      chk("t6_repeat1_time", pulse_t[base+1] - t0, DB + REP);
      chk("t6_repeat2_time", pulse_t[base+2] - t0, DB + 2 * REP);
    end
`else
    chk("t6_pulse_count", pulse_cnt, base + 1);
`endif

    // ---- reset during CONFIRM aborts the event ----
    base = pulse_cnt;
    k = 0;
    while (col_n != 4'b1110 && k < 40) begin
      @(negedge clk);
      k++;
    end
    press_mask[2*COLS+1] = 1'b1;
    k = 0;
    while (col_n != 4'b1101 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("rst_reached_col1", col_n, 4'b1101);
    repeat (10) @(negedge clk);
    n_reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("midpress_reset");
    press_mask = '0;
    n_reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_no_pulse", pulse_cnt, base);
    chk("rst_key_code_cleared", key_code, 0);
    chk("rst_not_held", key_held, 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
